// File: rtl/pipeline_fetch.sv
// Instruction-fetch stage: owns the PC, pipelines imem requests, buffers in-order responses.
// Optional FETCH_PERF_EN adds perf_fetch/perf_drop counters.
module pipeline_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        d_stall,
    output logic        f_valid,
    output logic [31:0] f_inst,
    output logic [31:0] f_p4,
    output logic [31:0] dbg_f_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_drop
`endif
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, tw_q, tw_d, tr_q, tr_d;

    logic [31:0] inst_mem [BUF_DEPTH];
    logic [31:0] pc_mem   [BUF_DEPTH];
    logic [31:0] tag_mem  [BUF_DEPTH];

    logic          pop, issue, rv, push, discard;
    logic [CW:0]   occ;

    // Outputs come only from the head registers, gated so reset reads as an idle stage.
    assign f_valid  = ~reset & (cnt_q != '0);
    assign f_inst   = f_valid ? inst_mem[rd_q] : 32'h0;
    assign dbg_f_pc = f_valid ? pc_mem[rd_q] : 32'h0;
    assign f_p4     = f_valid ? pc_mem[rd_q] + 32'd4 : 32'h0;

    assign pop       = f_valid & ~d_stall & ~redirect;
    assign occ       = (CW+1)'(cnt_q) + (CW+1)'(out_q) - (CW+1)'(pop);
    assign imem_req  = ~reset & ~redirect & (occ < (CW+1)'(BUF_DEPTH));
    assign imem_addr = pc_q;
    assign issue     = imem_req & imem_gnt;

    // Killed requests stay in out_q, so a response with out_q==0 is a stray and is ignored.
    assign rv      = imem_rvalid & (out_q != '0);
    assign push    = rv & ~redirect & (drop_q == '0);
    assign discard = rv & ~push;

    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        out_d  = out_q + CW'(issue) - CW'(rv);
        drop_d = drop_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        tw_d   = tw_q + AW'(issue);
        tr_d   = tr_q + AW'(rv);
        if (issue) begin
            pc_d = pc_q + 32'd4;
        end
        if (redirect) begin
            pc_d   = {redirect_pc[31:2], 2'b00};
            cnt_d  = '0;
            rd_d   = wr_q;
            drop_d = out_q - CW'(rv);
        end else begin
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            wr_d  = wr_q + AW'(push);
            rd_d  = rd_q + AW'(pop);
            if (rv && drop_q != '0) begin
                drop_d = drop_q - CW'(1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            cnt_q  <= '0;
            out_q  <= '0;
            drop_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            tw_q   <= '0;
            tr_q   <= '0;
        end else begin
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            drop_q <= drop_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            tw_q   <= tw_d;
            tr_q   <= tr_d;
        end
    end

    // The tag FIFO pairs each response with the PC it was issued for.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[tw_q] <= pc_q;
        end
        if (push) begin
            inst_mem[wr_q] <= imem_rdata;
            pc_mem[wr_q]   <= tag_mem[tr_q];
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_drop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_q + 32'(push);
            perf_drop_q  <= perf_drop_q + 32'(discard);
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_drop  = perf_drop_q;
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif
endmodule

// File: tb/tb_pipeline_fetch.sv
// Bench for pipeline_fetch: directed scenarios plus a randomized run against a queue-based model
// of the instruction memory and of the expected in-order fetch stream.
module tb_pipeline_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset, imem_req, imem_gnt, imem_rvalid, redirect, d_stall, f_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, f_inst, f_p4, dbg_f_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch, perf_drop;
`endif

    pipeline_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .d_stall(d_stall),
        .f_valid(f_valid), .f_inst(f_inst), .f_p4(f_p4), .dbg_f_pc(dbg_f_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetch(perf_fetch), .perf_drop(perf_drop)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [31:0] addr; } req_t;
    req_t        pend[$];
    logic [31:0] popped[$];
    logic [31:0] issued[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, last_due = 0, lat_lo = 1, lat_hi = 1, gnt_pct = 100;
    bit          force_late = 0, prev_hold = 0;
    logic [31:0] exp_issue = RESET_PC, exp_pop = RESET_PC, prev_pc, prev_inst;
    logic        obs_req, obs_fvalid;
    logic [31:0] obs_addr, obs_pc, obs_p4, obs_inst;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {~pc[31:16], pc[15:0] ^ 16'h3C5A};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_found(input string tag, input bit found);
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL %s observed=timeout expected=event", tag);
        end
    endtask

    // One clock cycle: drive memory response, check against the model, advance the model.
    task automatic step();
        bit late = 0;
        int d;
        imem_gnt    = (gnt_pct >= 100) ? 1'b1 : ($urandom_range(99) < gnt_pct);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (force_late) begin
            imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; force_late = 0; late = 1;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1; imem_rdata = inst_of(pend[0].addr);
        end
        #1;
        obs_req = imem_req; obs_addr = imem_addr; obs_fvalid = f_valid;
        obs_pc = dbg_f_pc; obs_p4 = f_p4; obs_inst = f_inst;
        if (reset) begin
            chk("rst_req", {31'b0, imem_req}, 32'h0);
            chk("rst_fvalid", {31'b0, f_valid}, 32'h0);
            chk("rst_inst", f_inst, 32'h0);
            chk("rst_p4", f_p4, 32'h0);
            chk("rst_pc", dbg_f_pc, 32'h0);
        end else begin
            if (redirect) chk("redir_req", {31'b0, imem_req}, 32'h0);
            if (imem_req) chk("issue_addr", imem_addr, exp_issue);
            if (prev_hold) begin
                chk("hold_valid", {31'b0, f_valid}, 32'h1);
                chk("hold_pc", dbg_f_pc, prev_pc);
                chk("hold_inst", f_inst, prev_inst);
            end
            if (!f_valid) begin
                chk("empty_inst", f_inst, 32'h0);
                chk("empty_p4", f_p4, 32'h0);
                chk("empty_pc", dbg_f_pc, 32'h0);
            end else if (!d_stall && !redirect) begin
                chk("pop_pc", dbg_f_pc, exp_pop);
                chk("pop_inst", f_inst, inst_of(exp_pop));
                chk("pop_p4", f_p4, exp_pop + 32'd4);
                popped.push_back(dbg_f_pc);
                exp_pop = exp_pop + 32'd4;
            end
        end
        prev_hold = !reset && f_valid && d_stall && !redirect;
        prev_pc   = dbg_f_pc;
        prev_inst = f_inst;
        if (reset) begin
            pend.delete();
            exp_issue = RESET_PC;
            exp_pop   = RESET_PC;
        end else begin
            if (imem_rvalid && !late) void'(pend.pop_front());
            if (imem_req && imem_gnt) begin
                d = cyc + $urandom_range(lat_hi, lat_lo);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                pend.push_back('{due: d, addr: imem_addr});
                issued.push_back(imem_addr);
                exp_issue = exp_issue + 32'd4;
            end
            if (redirect) begin
                exp_issue = {redirect_pc[31:2], 2'b00};
                exp_pop   = {redirect_pc[31:2], 2'b00};
            end
            chk("outstanding_le_depth", {31'b0, pend.size() <= DEPTH}, 32'h1);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int n, m, out0;
        bit found;
        logic [31:0] pd0;
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; d_stall = 1'b0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        pd0 = 32'h0;
        @(negedge clk);

        // T1: reset then first fetches
        step(); step();
`ifdef FETCH_PERF_EN
        chk("t1_perf_fetch_rst", perf_fetch, 32'h0);
        chk("t1_perf_drop_rst", perf_drop, 32'h0);
`endif
        reset = 1'b0;
        step(); chk("t1_req", {31'b0, obs_req}, 32'h1); chk("t1_addr0", obs_addr, 32'h0);
        chk("t1_fv0", {31'b0, obs_fvalid}, 32'h0);
        step(); chk("t1_addr4", obs_addr, 32'h4); chk("t1_fv1", {31'b0, obs_fvalid}, 32'h0);
        step(); chk("t1_addr8", obs_addr, 32'h8); chk("t1_fv2", {31'b0, obs_fvalid}, 32'h1);
        chk("t1_pc", obs_pc, 32'h0); chk("t1_p4", obs_p4, 32'h4);

        // T2: streaming, one per cycle
        for (int i = 0; i < 20; i++) begin
            step(); chk("t2_req", {31'b0, obs_req}, 32'h1);
        end
        chk("t2_npop", popped.size(), 32'd21);
        if (popped.size() == 21) chk("t2_last_pc", popped[20], 32'h50);

        // T3: stall at head pc 8
        redirect_pc = 32'h8; redirect = 1'b1; step(); redirect = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (f_valid && dbg_f_pc == 32'h8) found = 1; else step();
        end
        expect_found("t3_head8", found);
        d_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(); chk("t3_hold_pc", obs_pc, 32'h8);
        end
        chk("t3_req_off", {31'b0, obs_req}, 32'h0);
        n = popped.size();
        d_stall = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t3_npop", {31'b0, popped.size() >= n + 3}, 32'h1);
        if (popped.size() >= n + 3) begin
            chk("t3_pop0", popped[n], 32'h8);
            chk("t3_pop1", popped[n+1], 32'hC);
            chk("t3_pop2", popped[n+2], 32'h10);
        end

        // T4: redirect with two requests in flight, latency 3
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 6; i++) step();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend.size() == 2 && pend[0].due > cyc) found = 1; else step();
        end
        expect_found("t4_two_inflight", found);
`ifdef FETCH_PERF_EN
        pd0 = perf_drop;
`endif
        redirect_pc = 32'h100; redirect = 1'b1; step(); redirect = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (f_valid) found = 1; else step();
        end
        expect_found("t4_refetch", found);
        chk("t4_pc", dbg_f_pc, 32'h100);
`ifdef FETCH_PERF_EN
        chk("t4_perf_drop", perf_drop - pd0, 32'd2);
`endif

        // T5: redirect coinciding with rvalid and a would-be pop
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 5; i++) step();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (f_valid && pend.size() > 0 && pend[0].due <= cyc) found = 1; else step();
        end
        expect_found("t5_setup", found);
        out0 = pend.size();
`ifdef FETCH_PERF_EN
        pd0 = perf_drop;
`endif
        n = popped.size();
        redirect_pc = 32'h200; redirect = 1'b1; step(); redirect = 1'b0;
        step();
        chk("t5_flushed", {31'b0, obs_fvalid}, 32'h0);
        chk("t5_no_pop", popped.size(), n);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (f_valid) found = 1; else step();
        end
        expect_found("t5_refetch", found);
        chk("t5_pc", dbg_f_pc, 32'h200);
`ifdef FETCH_PERF_EN
        chk("t5_perf_drop", perf_drop - pd0, out0);
`endif

        // T6a: PC wrap, with a misaligned redirect target
        m = issued.size();
        redirect_pc = 32'hFFFF_FFF9; redirect = 1'b1; step(); redirect = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("t6_nissue", {31'b0, issued.size() >= m + 3}, 32'h1);
        if (issued.size() >= m + 3) begin
            chk("t6_addr_f8", issued[m], 32'hFFFF_FFF8);
            chk("t6_addr_fc", issued[m+1], 32'hFFFF_FFFC);
            chk("t6_addr_wrap", issued[m+2], 32'h0);
        end

        // T6b: reset with two outstanding, then a stray response
        lat_lo = 3; lat_hi = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend.size() == 2) found = 1; else step();
        end
        expect_found("t6_two_inflight", found);
        reset = 1'b1; step();
        chk("t6_rst_fv", {31'b0, obs_fvalid}, 32'h0);
        chk("t6_rst_req", {31'b0, obs_req}, 32'h0);
`ifdef FETCH_PERF_EN
        chk("t6_perf_drop_rst", perf_drop, 32'h0);
`endif
        reset = 1'b0; force_late = 1;
        step(); chk("t6_post_fv", {31'b0, obs_fvalid}, 32'h0);
        step(); chk("t6_late_ignored", {31'b0, obs_fvalid}, 32'h0);
        for (int i = 0; i < 6; i++) step();
        chk("t6_restart_pc", {31'b0, popped.size() > 0}, 32'h1);

        // Randomized traffic
        gnt_pct = 70; lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 400; i++) begin
            d_stall     = ($urandom_range(3) == 0);
            redirect    = ($urandom_range(24) == 0);
            redirect_pc = $urandom;
            step();
        end
        redirect = 1'b0; d_stall = 1'b0;
        for (int i = 0; i < 10; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
